// File: rtl/axi_rd_pkg.sv
// Shared constants and FSM state type for the AXI4 read burst master.
package axi_rd_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int AXI_4K_BYTES = 4096;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/axi_rd_burst_calc.sv
// Next burst length: min(remaining beats, MAX_BURST, beats left before the 4 KB page end).
module axi_rd_burst_calc
    import axi_rd_pkg::*;
#(
    parameter int LEN_WIDTH = 16,
    parameter int MAX_BURST = 16,
    parameter int BYTES     = 16
) (
    input  logic [LEN_WIDTH-1:0] ar_rem_i,
    input  logic [11:0]          addr_lo_i,
    output logic [8:0]           burst_o,
    output logic [7:0]           arlen_o
);

    localparam int SIZE = $clog2(BYTES);

    logic [12:0] bytes_to_4k;
    logic [12:0] beats_to_4k;
    logic [31:0] rem_w;
    logic [31:0] cap;

    always_comb begin
        bytes_to_4k = 13'(AXI_4K_BYTES) - {1'b0, addr_lo_i};
        beats_to_4k = bytes_to_4k >> SIZE;
        rem_w       = 32'(ar_rem_i);
        cap         = 32'(MAX_BURST);
        if (32'(beats_to_4k) < cap) begin
            cap = 32'(beats_to_4k);
        end
        if (rem_w < cap) begin
            cap = rem_w;
        end
        burst_o = 9'(cap);
        // Don't-care when nothing remains; arvalid is low then.
        arlen_o = 8'(cap - 32'd1);
    end

endmodule

// File: rtl/axi_rd_burst_master.sv
// AXI4 read master: splits (addr, beats) commands into INCR bursts and streams R data out.
// Optional build macro AXI_RD_PERF_CNT_EN adds busy/stall cycle counters.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | issuing AR bursts and forwarding R beats until the last beat
module axi_rd_burst_master
    import axi_rd_pkg::*;
#(
    parameter int DATA_WIDTH      = 128,
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int LEN_WIDTH       = 16,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int AXI_ID          = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  m_axi_arvalid,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [1:0]            m_axi_arburst,
    output logic [2:0]            m_axi_arsize,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arlock,
    input  logic                  m_axi_arready,
    input  logic                  m_axi_rvalid,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                  m_axi_rlast,
    input  logic [1:0]            m_axi_rresp,
    output logic                  m_axi_rready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
`ifdef AXI_RD_PERF_CNT_EN
    ,
    output logic [31:0]           perf_busy_cyc,
    output logic [31:0]           perf_stall_cyc
`endif
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    state_e                 state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [ADDR_WIDTH-1:0]  addr_d;
    logic [LEN_WIDTH-1:0]   ar_rem_q;
    logic [LEN_WIDTH-1:0]   r_rem_q;
    logic [OUT_W-1:0]       outst_q;
    logic                   err_q;
    logic                   done_q;

    logic       run;
    logic       ar_hs;
    logic       r_hs;
    logic       rlast_hs;
    logic [8:0] burst;
    logic [7:0] arlen;
    logic       unused_rid;

    axi_rd_burst_calc #(
        .LEN_WIDTH (LEN_WIDTH),
        .MAX_BURST (MAX_BURST),
        .BYTES     (BYTES)
    ) u_calc (
        .ar_rem_i  (ar_rem_q),
        .addr_lo_i (addr_q[11:0]),
        .burst_o   (burst),
        .arlen_o   (arlen)
    );

    // Only one ID is ever issued, so rid carries no information.
    assign unused_rid = ^m_axi_rid;

    assign run      = (state_q == RUN);
    assign addr_d   = addr_q + (ADDR_WIDTH'(burst) << SIZE);
    assign ar_hs    = m_axi_arvalid && m_axi_arready;
    assign r_hs     = run && m_axi_rvalid && m_ready;
    assign rlast_hs = r_hs && m_axi_rlast;

    assign cmd_ready = !run && !rst;
    assign busy      = run;
    assign done      = done_q;
    assign err       = err_q;

    assign m_axi_arvalid = run && (ar_rem_q != '0) && (outst_q < OUT_W'(MAX_OUTSTANDING));
    assign m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = arlen;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arlock  = 1'b0;

    // Unbuffered R pass-through, gated so nothing leaks out while idle or in reset.
    assign m_axi_rready = run && m_ready;
    assign m_valid      = run && m_axi_rvalid;
    assign m_data       = run ? m_axi_rdata : '0;
    assign m_last       = m_valid && (r_rem_q == LEN_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            ar_rem_q <= '0;
            r_rem_q  <= '0;
            outst_q  <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        err_q <= 1'b0;
                        if (cmd_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            addr_q   <= cmd_addr;
                            ar_rem_q <= cmd_len;
                            r_rem_q  <= cmd_len;
                            outst_q  <= '0;
                            state_q  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (ar_hs) begin
                        addr_q   <= addr_d;
                        ar_rem_q <= ar_rem_q - LEN_WIDTH'(burst);
                    end
                    if (ar_hs && !rlast_hs) begin
                        outst_q <= outst_q + OUT_W'(1);
                    end else if (!ar_hs && rlast_hs && outst_q != '0) begin
                        outst_q <= outst_q - OUT_W'(1);
                    end
                    if (r_hs) begin
                        r_rem_q <= r_rem_q - LEN_WIDTH'(1);
                        if (m_axi_rresp != RESP_OKAY) begin
                            err_q <= 1'b1;
                        end
                        if (r_rem_q == LEN_WIDTH'(1)) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef AXI_RD_PERF_CNT_EN
    logic [31:0] busy_cyc_q;
    logic [31:0] stall_cyc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cyc_q  <= '0;
            stall_cyc_q <= '0;
        end else if (cmd_valid && cmd_ready) begin
            busy_cyc_q  <= '0;
            stall_cyc_q <= '0;
        end else begin
            if (run && busy_cyc_q != '1) begin
                busy_cyc_q <= busy_cyc_q + 32'd1;
            end
            if (m_valid && !m_ready && stall_cyc_q != '1) begin
                stall_cyc_q <= stall_cyc_q + 32'd1;
            end
        end
    end

    assign perf_busy_cyc  = busy_cyc_q;
    assign perf_stall_cyc = stall_cyc_q;
`endif

endmodule

// File: tb/tb_axi_rd_burst_master.sv
// Scoreboard bench for axi_rd_burst_master with a simple AXI read slave model.
module tb_axi_rd_burst_master;
    import axi_rd_pkg::*;

    localparam int DW = 128;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          busy, done, err;
    logic          m_axi_arvalid;
    logic [IW-1:0] m_axi_arid;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [1:0]    m_axi_arburst;
    logic [2:0]    m_axi_arsize;
    logic [3:0]    m_axi_arcache;
    logic [2:0]    m_axi_arprot;
    logic          m_axi_arlock;
    logic          m_axi_arready = 1'b0;
    logic          m_axi_rvalid = 1'b0;
    logic [IW-1:0] m_axi_rid = '0;
    logic [DW-1:0] m_axi_rdata = '0;
    logic          m_axi_rlast = 1'b0;
    logic [1:0]    m_axi_rresp = 2'b00;
    logic          m_axi_rready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready = 1'b1;
`ifdef AXI_RD_PERF_CNT_EN
    logic [31:0]   perf_busy_cyc, perf_stall_cyc;
`endif

    axi_rd_burst_master #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .ID_WIDTH        (IW),
        .LEN_WIDTH       (LW),
        .MAX_BURST       (16),
        .MAX_OUTSTANDING (2),
        .AXI_ID          (0)
    ) dut (
        .clk (clk), .rst (rst),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_addr (cmd_addr), .cmd_len (cmd_len),
        .busy (busy), .done (done), .err (err),
        .m_axi_arvalid (m_axi_arvalid), .m_axi_arid (m_axi_arid), .m_axi_araddr (m_axi_araddr),
        .m_axi_arlen (m_axi_arlen), .m_axi_arburst (m_axi_arburst), .m_axi_arsize (m_axi_arsize),
        .m_axi_arcache (m_axi_arcache), .m_axi_arprot (m_axi_arprot), .m_axi_arlock (m_axi_arlock),
        .m_axi_arready (m_axi_arready),
        .m_axi_rvalid (m_axi_rvalid), .m_axi_rid (m_axi_rid), .m_axi_rdata (m_axi_rdata),
        .m_axi_rlast (m_axi_rlast), .m_axi_rresp (m_axi_rresp), .m_axi_rready (m_axi_rready),
        .m_valid (m_valid), .m_data (m_data), .m_last (m_last), .m_ready (m_ready)
`ifdef AXI_RD_PERF_CNT_EN
        , .perf_busy_cyc (perf_busy_cyc), .perf_stall_cyc (perf_stall_cyc)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] pat(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, a, ~a, a + 32'h1234_5678};
    endfunction

    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [127:0] data; logic last; } beat_t;

    ar_t   exp_ar[$];
    beat_t exp_beat[$];
    logic  exp_done[$];

    task automatic exp_burst(input logic [31:0] a, input logic [7:0] l);
        exp_ar.push_back('{a, l});
    endtask

    task automatic exp_cmd(input logic [31:0] a, input int len, input logic e);
        for (int k = 0; k < len; k++) begin
            exp_beat.push_back('{pat(a + 32'(16 * k)), (k == len - 1)});
        end
        exp_done.push_back(e);
    endtask

    // Slave model
    logic        r_en = 1'b1;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    int          ar_times[$];
    int          rlast_times[$];

    initial begin
        ar_t         sl_q[$];
        int          sl_beat = 0;
        logic        ar_fire, r_fire, rl;
        logic [31:0] a, ba;
        logic [7:0]  l;
        forever begin
            @(negedge clk);
            ar_fire = m_axi_arvalid && m_axi_arready;
            r_fire  = m_axi_rvalid && m_axi_rready;
            rl      = m_axi_rlast;
            a       = m_axi_araddr;
            l       = m_axi_arlen;
            @(posedge clk);
            #1;
            if (rst) begin
                sl_q.delete();
                sl_beat = 0;
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
                m_axi_arready = 1'b1;
            end else begin
                if (ar_fire) begin
                    sl_q.push_back('{a, l});
                    ar_times.push_back(cyc);
                end
                if (r_fire && sl_q.size() > 0) begin
                    if (rl) rlast_times.push_back(cyc);
                    if (sl_beat == int'(sl_q[0].len)) begin
                        void'(sl_q.pop_front());
                        sl_beat = 0;
                    end else begin
                        sl_beat++;
                    end
                end
                m_axi_arready = 1'b1;
                m_axi_rvalid  = r_en && (sl_q.size() > 0);
                if (m_axi_rvalid) begin
                    ba          = sl_q[0].addr + 32'(16 * sl_beat);
                    m_axi_rdata = pat(ba);
                    m_axi_rlast = (sl_beat == int'(sl_q[0].len));
                    m_axi_rresp = (ba == err_addr) ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    m_axi_rlast = 1'b0;
                    m_axi_rresp = RESP_OKAY;
                end
            end
        end
    end

    logic mr_toggle = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = mr_toggle ? ~m_ready : 1'b1;
        end
    end

    // Monitor / scoreboard
    initial begin
        ar_t   ea;
        beat_t eb;
        logic  ed;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m_axi_arvalid && m_axi_arready) begin
                    if (exp_ar.size() == 0) begin
                        total++; bad++;
                        $display("FAIL ar_unexpected got araddr=%0h required none", m_axi_araddr);
                    end else begin
                        ea = exp_ar.pop_front();
                        chk("araddr", m_axi_araddr, ea.addr);
                        chk("arlen", m_axi_arlen, ea.len);
                    end
                end
                if (busy) chk("rready_mirror", m_axi_rready, m_ready);
                if (m_valid && m_ready) begin
                    if (exp_beat.size() == 0) begin
                        total++; bad++;
                        $display("FAIL beat_unexpected got data=%0h required none", m_data);
                    end else begin
                        eb = exp_beat.pop_front();
                        chk("beat_data", m_data, eb.data);
                        chk("beat_last", m_last, eb.last);
                    end
                end
                if (done) begin
                    if (exp_done.size() == 0) begin
                        total++; bad++;
                        $display("FAIL done_unexpected got done=1 required 0");
                    end else begin
                        ed = exp_done.pop_front();
                        chk("done_err", err, ed);
                        chk("done_busy", busy, 0);
                    end
                end
            end
        end
    end

    task automatic issue_cmd(input logic [31:0] a, input logic [15:0] l);
        int n = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 100);
        chk("cmd_ready_accept", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        chk("done_seen", done, 1);
        chk("beats_drained", 128'(exp_beat.size()), 0);
        chk("ars_drained", 128'(exp_ar.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_ar, base_rl;

        // Reset state
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_m_valid", m_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("arburst", m_axi_arburst, 2'b01);
        chk("arsize", m_axi_arsize, 3'd4);
        chk("arcache", m_axi_arcache, 4'b0011);
        chk("arid", m_axi_arid, 0);

        // 1: 4K split
        exp_burst(32'h0FE0, 8'd1);
        exp_burst(32'h1000, 8'd1);
        exp_cmd(32'h0FE0, 4, 1'b0);
        issue_cmd(32'h0FE0, 16'd4);
        chk("busy_run", busy, 1);
        wait_done(200);

        // 2: MAX_BURST split
        exp_burst(32'h1000, 8'd15);
        exp_burst(32'h1100, 8'd15);
        exp_burst(32'h1200, 8'd7);
        exp_cmd(32'h1000, 40, 1'b0);
        issue_cmd(32'h1000, 16'd40);
        wait_done(400);

        // 3: outstanding limit of 2
        r_en    = 1'b0;
        base_ar = ar_times.size();
        base_rl = rlast_times.size();
        exp_burst(32'h2000, 8'd15);
        exp_burst(32'h2100, 8'd15);
        exp_burst(32'h2200, 8'd15);
        exp_cmd(32'h2000, 48, 1'b0);
        issue_cmd(32'h2000, 16'd48);
        repeat (12) @(negedge clk);
        chk("ar_cnt_limited", 128'(ar_times.size() - base_ar), 2);
        r_en = 1'b1;
        wait_done(400);
        chk("ar3_after_rlast",
            (ar_times.size() > base_ar + 2 && rlast_times.size() > base_rl) ?
            128'(ar_times[base_ar + 2] > rlast_times[base_rl]) : 128'd0, 1);

        // 4: m_ready toggling
        mr_toggle = 1'b1;
        exp_burst(32'h4F00, 8'd15);
        exp_cmd(32'h4F00, 16, 1'b0);
        issue_cmd(32'h4F00, 16'd16);
        wait_done(400);
        mr_toggle = 1'b0;

        // 5: SLVERR on beat 3, then cleared on next accept
        err_addr = 32'h5020;
        exp_burst(32'h5000, 8'd7);
        exp_cmd(32'h5000, 8, 1'b1);
        issue_cmd(32'h5000, 16'd8);
        wait_done(200);
        err_addr = 32'hFFFF_FFFF;
        exp_burst(32'h6000, 8'd0);
        exp_cmd(32'h6000, 1, 1'b0);
        issue_cmd(32'h6000, 16'd1);
        chk("err_cleared", err, 0);
        wait_done(200);

        // 6a: zero-length command
        exp_done.push_back(1'b0);
        issue_cmd(32'h0000, 16'd0);
        @(negedge clk);
        chk("len0_done", done, 1);
        chk("len0_arvalid", m_axi_arvalid, 0);
        chk("len0_busy", busy, 0);

        // 6b: reset mid-burst
        exp_burst(32'h3000, 8'd15);
        exp_burst(32'h3100, 8'd15);
        exp_cmd(32'h3000, 32, 1'b0);
        issue_cmd(32'h3000, 16'd32);
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_arvalid", m_axi_arvalid, 0);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_m_data", m_data, 0);
        chk("mid_rst_rready", m_axi_rready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        exp_ar.delete();
        exp_beat.delete();
        exp_done.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_busy", busy, 0);

        // Recovery, page boundary with more beats remaining than fit
        exp_burst(32'h7FF0, 8'd0);
        exp_burst(32'h8000, 8'd1);
        exp_cmd(32'h7FF0, 3, 1'b0);
        issue_cmd(32'h7FF0, 16'd3);
        wait_done(200);
        chk("done_drained", 128'(exp_done.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
